// File: rtl/p2s_serializer.sv
// p2s_serializer: loads a DWIDTH-bit word when empty and shifts it out one bit per clock.
// Ports: clk, rstn, indata/invalid in; empty, dout, valid out. Build macro: P2S_LSB_FIRST_EN.
module p2s_serializer #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DWIDTH-1:0] indata,
  input  logic              invalid,
  output logic              empty,
  output logic              dout,
  output logic              valid
);

  localparam int CW = $clog2(DWIDTH);

  logic [DWIDTH-2:0] sreg_q, sreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              accept, shift;

  assign empty  = (cnt_q == '0);
  assign accept = invalid && empty;
  assign shift  = !empty;
  assign dout   = dout_q;
  assign valid  = valid_q;

  // Idle drives dout low so nothing undefined leaks out while valid is low.
  always_comb begin
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    dout_d  = 1'b0;
    valid_d = 1'b0;
    unique case (1'b1)
      accept: begin
`ifdef P2S_LSB_FIRST_EN
        dout_d = indata[0];
        sreg_d = indata[DWIDTH-1:1];
`else
        dout_d = indata[DWIDTH-1];
        sreg_d = indata[DWIDTH-2:0];
`endif
        cnt_d   = CW'(DWIDTH - 1);
        valid_d = 1'b1;
      end
      shift: begin
`ifdef P2S_LSB_FIRST_EN
        dout_d = sreg_q[0];
        sreg_d = sreg_q >> 1;
`else
        dout_d = sreg_q[DWIDTH-2];
        sreg_d = sreg_q << 1;
`endif
        cnt_d   = cnt_q - CW'(1);
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sreg_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_p2s_serializer.sv
// tb_p2s_serializer: directed bench for p2s_serializer at DWIDTH=4.
// Scoreboard queue holds expected serial bits; fixed patterns are also checked.
module tb_p2s_serializer;

  localparam int DW = 4;

  logic          clk;
  logic          rstn;
  logic [DW-1:0] indata;
  logic          invalid;
  logic          empty;
  logic          dout;
  logic          valid;

  int   n_chk;
  int   n_fail;
  int   mcnt;
  bit   sb_q[$];
  logic [7:0] got;
  int   nv;

  p2s_serializer #(.DWIDTH(DW)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .indata (indata),
    .invalid(invalid),
    .empty  (empty),
    .dout   (dout),
    .valid  (valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
`ifdef P2S_LSB_FIRST_EN
    for (int i = 0; i < DW; i++) sb_q.push_back(w[i]);
`else
    for (int i = DW - 1; i >= 0; i--) sb_q.push_back(w[i]);
`endif
  endtask

  task automatic step();
    bit acc;
    bit busy;
    bit exp_v;
    bit e;
    acc  = 1'b0;
    busy = 1'b0;
    if (rstn === 1'b1) begin
      acc  = (invalid === 1'b1) && (mcnt == 0);
      busy = (mcnt != 0);
      if (acc) begin
        push_word(indata);
        mcnt = DW - 1;
      end else if (busy) begin
        mcnt--;
      end
    end else begin
      mcnt = 0;
      sb_q.delete();
    end
    @(posedge clk);
    #1;
    exp_v = acc || busy;
    chk("valid", {7'b0, valid}, {7'b0, exp_v});
    chk("empty", {7'b0, empty}, {7'b0, mcnt == 0});
    if (exp_v) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 8'd1, 8'd0);
      end else begin
        e = sb_q.pop_front();
        chk("dout", {7'b0, dout}, {7'b0, e});
      end
      got = {got[6:0], dout};
      nv++;
    end else begin
      chk("dout_idle", {7'b0, dout}, 8'd0);
    end
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    mcnt    = 0;
    got     = '0;
    nv      = 0;
    indata  = '0;
    invalid = 1'b0;
    rstn    = 1'b1;
    #1 rstn = 1'b0;
    #1;
    chk("rst_pre_valid", {7'b0, valid}, 8'd0);
    chk("rst_pre_dout", {7'b0, dout}, 8'd0);
    chk("rst_pre_empty", {7'b0, empty}, 8'd1);
    step();
    step();
    rstn = 1'b1;

    // single word 1010, invalid held 4 cycles
    got = '0;
    nv = 0;
    indata  = 4'b1010;
    invalid = 1'b1;
    step();
    chk("single_empty1", {7'b0, empty}, 8'd0);
    step();
    chk("single_empty2", {7'b0, empty}, 8'd0);
    step();
    chk("single_empty3", {7'b0, empty}, 8'd0);
    step();
    chk("single_empty4", {7'b0, empty}, 8'd1);
    invalid = 1'b0;
    step();
    chk("single_after_valid", {7'b0, valid}, 8'd0);
    chk("single_cnt", nv[7:0], 8'd4);
`ifdef P2S_LSB_FIRST_EN
    chk("single_bits", {4'b0, got[3:0]}, 8'b0000_0101);
`else
    chk("single_bits", {4'b0, got[3:0]}, 8'b0000_1010);
`endif

    // back-to-back 1100 then 0011
    got = '0;
    nv = 0;
    indata  = 4'b1100;
    invalid = 1'b1;
    repeat (4) step();
    indata = 4'b0011;
    repeat (4) step();
    invalid = 1'b0;
    chk("b2b_cnt", nv[7:0], 8'd8);
`ifdef P2S_LSB_FIRST_EN
    chk("b2b_bits", got, 8'b0011_1100);
`else
    chk("b2b_bits", got, 8'b1100_0011);
`endif
    step();
    chk("b2b_idle", {7'b0, valid}, 8'd0);

    // busy hold: 0110 in flight, indata switches to 1111
    got = '0;
    nv = 0;
    indata  = 4'b0110;
    invalid = 1'b1;
    step();
    indata = 4'b1111;
    repeat (3) step();
    chk("busy_first", {4'b0, got[3:0]}, 8'b0000_0110);
    step();
    invalid = 1'b0;
    repeat (3) step();
    step();
    chk("busy_cnt", nv[7:0], 8'd8);
    chk("busy_bits", got, 8'b0110_1111);

    // reset mid-word after two bits of 1010
    indata  = 4'b1010;
    invalid = 1'b1;
    step();
    step();
    invalid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("midrst_valid", {7'b0, valid}, 8'd0);
    chk("midrst_dout", {7'b0, dout}, 8'd0);
    chk("midrst_empty", {7'b0, empty}, 8'd1);
    step();
    rstn = 1'b1;

    // first accept right after release, word 1000
    got = '0;
    nv = 0;
    indata  = 4'b1000;
    invalid = 1'b1;
    step();
    invalid = 1'b0;
    repeat (3) step();
    step();
    chk("order_cnt", nv[7:0], 8'd4);
`ifdef P2S_LSB_FIRST_EN
    chk("order_bits", {4'b0, got[3:0]}, 8'b0000_0001);
`else
    chk("order_bits", {4'b0, got[3:0]}, 8'b0000_1000);
`endif
    chk("sb_drained", sb_q.size(), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
